// File: rtl/seg7_capture_if.sv
// Bus bundle for seg7_capture: raw segment input, control strobes and decoded status.
interface seg7_capture_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic [6:0]       seg_in;
    logic             clear_err;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             pat_err;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, seg_in, clear_err,
        input  digit, digit_valid, blank, pat_err, seq_err, err_count
    );

    modport slave (
        input  en, seg_in, clear_err,
        output digit, digit_valid, blank, pat_err, seq_err, err_count
    );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment capture: synchronize, glitch-filter and decode a segment bus back to hex,
// checking that successive digits count up by one (mod 16) and tallying malformed patterns.
//
// state | meaning
// IDLE  | no reference digit; next legal glyph is accepted without a sequence check
// TRACK | digit holds the reference; next legal glyph must equal digit+1 mod 16
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_capture_if.slave  bus
);
    localparam logic [7:0]       STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]       STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic {IDLE, TRACK} state_t;

    state_t           state, state_nx;
    logic [6:0]       s1, s2, cand, acc;
    logic [7:0]       stab;
    logic             accept;
    logic             glyph_ok;
    logic [3:0]       glyph_val;
    logic [3:0]       digit_q, digit_nx;
    logic             valid_q, valid_nx;
    logic             blank_q, blank_nx;
    logic             perr_q, perr_nx;
    logic             serr_q, serr_nx;
    logic [ERR_W-1:0] ecnt_q, ecnt_nx, ecnt_base;
    logic             seq_break, err_event;

    // An unchanged display never re-accepts because cand must differ from acc.
    assign accept = bus.en && (stab == STAB_LAST) && (s2 == cand) && (cand != acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            stab <= '0;
            acc  <= '0;
        end else begin
            s1 <= bus.seg_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                stab <= '0;
            end else if (!bus.en) begin
                stab <= '0;
            end else if (stab < STAB_MAX) begin
                stab <= stab + 8'd1;
            end
            if (accept) acc <= cand;
        end
    end

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (cand)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        digit_nx  = digit_q;
        valid_nx  = 1'b0;
        blank_nx  = blank_q;
        perr_nx   = 1'b0;
        seq_break = 1'b0;
        if (accept) begin
            if (cand == 7'h00) begin
                blank_nx = 1'b1;
                state_nx = IDLE;
            end else if (glyph_ok) begin
                digit_nx = glyph_val;
                valid_nx = 1'b1;
                blank_nx = 1'b0;
                state_nx = TRACK;
                seq_break = (state == TRACK) && (glyph_val != digit_q + 4'd1);
            end else begin
                perr_nx  = 1'b1;
                blank_nx = 1'b0;
                state_nx = IDLE;
            end
        end
        // Clear takes effect first so a coincident error still counts.
        err_event = perr_nx || seq_break;
        ecnt_base = bus.clear_err ? '0 : ecnt_q;
        ecnt_nx   = (err_event && ecnt_base != ERR_MAX) ? ecnt_base + 1'b1 : ecnt_base;
        serr_nx   = (bus.clear_err ? 1'b0 : serr_q) | seq_break;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            digit_q <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b1;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state   <= state_nx;
            digit_q <= digit_nx;
            valid_q <= valid_nx;
            blank_q <= blank_nx;
            perr_q  <= perr_nx;
            serr_q  <= serr_nx;
            ecnt_q  <= ecnt_nx;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = blank_q;
    assign bus.pat_err     = perr_q;
    assign bus.seq_err     = serr_q;
    assign bus.err_count   = ecnt_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: vector table plus timed corner sequences,
// with a scoreboard of expected digit_valid / pat_err events.
module tb_seg7_capture;
    localparam int SC = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_capture_if #(.ERR_W(EW)) bus ();
    seg7_capture #(.STABLE_CYCLES(SC), .ERR_W(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       is_perr;
        logic [3:0] digit;
        logic       seq_err;
        logic [7:0] cnt;
    } ev_t;

    typedef struct {
        logic [6:0] seg;
        int         ev;       // 0 none, 1 digit_valid, 2 pat_err
        logic [3:0] digit;
        logic       blank;
        logic       seq_err;
        logic [7:0] cnt;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[13];
    logic [6:0] glyph[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic is_perr, input logic [3:0] d, input logic se, input logic [7:0] c);
        ev_t e;
        e.is_perr = is_perr;
        e.digit   = d;
        e.seq_err = se;
        e.cnt     = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (bus.digit_valid || bus.pat_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got valid=%0b pat_err=%0b digit=%0h, expected none",
                         bus.digit_valid, bus.pat_err, bus.digit);
            end else begin
                e = sb.pop_front();
                chk("ev_pat_err", bus.pat_err, e.is_perr);
                chk("ev_digit_valid", bus.digit_valid, !e.is_perr);
                chk("ev_digit", bus.digit, e.digit);
                chk("ev_seq_err", bus.seq_err, e.seq_err);
                chk("ev_err_count", bus.err_count, e.cnt);
            end
        end
    end

    task automatic apply_vec(input vec_t v, input int idx);
        if (v.ev == 1) push_ev(1'b0, v.digit, v.seq_err, v.cnt);
        if (v.ev == 2) push_ev(1'b1, v.digit, v.seq_err, v.cnt);
        bus.seg_in = v.seg;
        repeat (20) @(negedge clk);
        chk($sformatf("vec%0d_digit", idx), bus.digit, v.digit);
        chk($sformatf("vec%0d_blank", idx), bus.blank, v.blank);
        chk($sformatf("vec%0d_seq_err", idx), bus.seq_err, v.seq_err);
        chk($sformatf("vec%0d_err_count", idx), bus.err_count, v.cnt);
        chk($sformatf("vec%0d_events_drained", idx), sb.size(), 0);
    endtask

    // k counts negedges after the drive; k==n means the pulse follows edge E(n).
    task automatic run_timed(input logic [6:0] pat, input int en_off_k, input int en_on_k,
                             input int clr_k, input int exp_k, input string name);
        int seen;
        seen = -1;
        bus.seg_in = pat;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            @(negedge clk);
            if (bus.digit_valid || bus.pat_err) seen = k;
            if (k == en_off_k) bus.en = 1'b0;
            if (k == en_on_k) bus.en = 1'b1;
            bus.clear_err = (k == clr_k);
        end
        bus.clear_err = 1'b0;
        chk(name, seen, exp_k);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0]  = '{7'h06, 1, 4'h1, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{7'h5B, 1, 4'h2, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{7'h00, 0, 4'h2, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{7'h71, 1, 4'hF, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{7'h3F, 1, 4'h0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{7'h4F, 1, 4'h3, 1'b0, 1'b1, 8'd1};
        vecs[6]  = '{7'h01, 2, 4'h3, 1'b0, 1'b1, 8'd2};
        vecs[7]  = '{7'h06, 1, 4'h1, 1'b0, 1'b1, 8'd2};
        vecs[8]  = '{7'h00, 0, 4'h1, 1'b1, 1'b1, 8'd2};
        vecs[9]  = '{7'h5B, 1, 4'h2, 1'b0, 1'b1, 8'd2};
        vecs[10] = '{7'h6D, 1, 4'h5, 1'b0, 1'b1, 8'd3};
        vecs[11] = '{7'h7C, 1, 4'hB, 1'b0, 1'b1, 8'd4};
        vecs[12] = '{7'h5E, 1, 4'hD, 1'b0, 1'b1, 8'd5};

        bus.en = 1'b1;
        bus.seg_in = 7'h00;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digit", bus.digit, 0);
        chk("rst_blank", bus.blank, 1);
        chk("rst_digit_valid", bus.digit_valid, 0);
        chk("rst_err_count", bus.err_count, 0);
        rst_n = 1'b1;

        // Blank bus after reset must stay silent.
        repeat (20) @(negedge clk);
        chk("idle_blank", bus.blank, 1);

        push_ev(1'b0, 4'h0, 1'b0, 8'd0);
        run_timed(7'h3F, -1, -1, -1, 6, "first_latency");
        chk("first_blank", bus.blank, 0);

        apply_vec(vecs[0], 0);

        bus.seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        bus.seg_in = 7'h06;
        repeat (20) @(negedge clk);
        chk("glitch_digit", bus.digit, 1);
        chk("glitch_err_count", bus.err_count, 0);

        for (int i = 1; i < 13; i++) apply_vec(vecs[i], i);

        // Sequence break (expected E, drive 0) accepted on the same edge as clear_err.
        push_ev(1'b0, 4'h0, 1'b1, 8'd1);
        run_timed(7'h3F, -1, -1, 5, 6, "clear_collision_latency");
        chk("clear_collision_err_count", bus.err_count, 1);
        chk("clear_collision_seq_err", bus.seq_err, 1);

        for (int i = 0; i < 300; i++) begin
            push_ev(1'b1, 4'h0, 1'b1, (i + 2 > 255) ? 8'd255 : 8'(i + 2));
            bus.seg_in = (i % 2 == 0) ? 7'h01 : 7'h02;
            repeat (8) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("saturate_err_count", bus.err_count, 255);
        chk("saturate_events_drained", sb.size(), 0);

        bus.seg_in = 7'h06;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_digit", bus.digit, 0);
        chk("midrst_blank", bus.blank, 1);
        chk("midrst_pat_err", bus.pat_err, 0);
        chk("midrst_seq_err", bus.seq_err, 0);
        chk("midrst_err_count", bus.err_count, 0);
        push_ev(1'b0, 4'h1, 1'b0, 8'd0);
        rst_n = 1'b1;
        run_timed(7'h06, -1, -1, -1, 6, "refilter_latency");

        push_ev(1'b0, 4'h2, 1'b0, 8'd0);
        run_timed(7'h5B, 4, 6, -1, 10, "en_gap_latency");

        for (int d = 3; d < 19; d++) begin
            push_ev(1'b0, 4'(d % 16), 1'b0, 8'd0);
            bus.seg_in = glyph[d % 16];
            repeat (12) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("selfloop_err_count", bus.err_count, 0);
        chk("selfloop_seq_err", bus.seq_err, 0);
        chk("selfloop_digit", bus.digit, 2);
        chk("end_events_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Seven-segment capture and decode block, the receive-side counterpart of the on-chip hex-to-segment encoder. It samples an external seven-segment bus (e.g. another board's display lines on `ui_in[6:0]`), filters glitches, and decodes each stable pattern back to a hex digit. It also checks that successive digits form the +1 mod 16 count sequence produced by the display counter, and tallies malformed patterns and sequence breaks for readout on `uo_out`/`uio_out`.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a pattern is accepted. Legal range 1–255.
- `ERR_W`, default 8: width of `err_count`.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  capture enable. Low holds the stability counter at 0 and blocks acceptance. The synchronizer keeps running.
- `seg_in`  in  7  raw segments, bit0=a … bit6=g, active-high, asynchronous to `clk`.
- `clear_err`  in  1  one-cycle request that clears `seq_err` and `err_count`.
- `digit`  out  4  last successfully decoded digit.
- `digit_valid`  out  1  one-cycle pulse when `digit` is updated.
- `blank`  out  1  level: the last accepted pattern is 0x00.
- `pat_err`  out  1  one-cycle pulse: the accepted pattern is not a legal hex glyph and not blank.
- `seq_err`  out  1  sticky: a sequence break has occurred since reset or the last `clear_err`.
- `err_count`  out  ERR_W  saturating count of `pat_err` events plus sequence breaks.

## Operation
- **Synchronizer:** two flops on all 7 bits. `s2` is the synchronized sample.
- **Stability filter:** register `cand`, counter `stab` with width 8.
  - If `s2 != cand`, load `cand <= s2` and `stab <= 0`.
  - Otherwise, if `en`, increment `stab`, saturating at `STABLE_CYCLES`.
- **Accept event:** fires when `en`, `stab == STABLE_CYCLES-1`, `s2 == cand`, and `cand != acc`. On accept, `acc <= cand`. An unchanged display never re-triggers an accept.
- **Legal glyphs (gfedcba hex), team encoding:**
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- **FSM states:** IDLE (no reference digit) and TRACK (reference digit held in `digit`).
- **Accepted pattern = 0x00:**
  - `blank <= 1`; state → IDLE.
  - No `digit_valid`, no error.
- **Accepted legal glyph d:**
  - `digit <= d`, `digit_valid` pulses, `blank <= 0`.
  - In IDLE: state → TRACK, no check.
  - In TRACK: if d != (`digit`+1) mod 16, set `seq_err` and increment `err_count`; state stays TRACK.
  - Wrap-around F→0 is legal.
- **Accepted illegal pattern:**
  - `pat_err` pulses and `err_count` increments.
  - `blank <= 0`, state → IDLE; `digit` is unchanged.
- **`err_count`:** saturates at 2^ERR_W−1.
  - `clear_err` coincident with an error event: the clear applies first and the event then counts, so `err_count` = 1 and `seq_err` = 1 if the event is a sequence break.
- **Reset values:**
  - `digit`=0, `digit_valid`=0, `blank`=1, `pat_err`=0, `seq_err`=0, `err_count`=0.
  - `acc`=0x00, `cand`=0x00, `stab`=0, synchronizer=0, state IDLE.
  - Reset mid-filter discards the pending pattern.
- **Encoder self-loop:** a blank bus after reset causes no event. Reconnecting the on-chip encoder output reproduces its own digits in order with zero errors.

## Timing
- Edge E0 is the first edge at which the synchronizer's first flop samples a new `seg_in` value that is then held.
  - `s2` holds the new value after E1.
  - `cand` loads at E2.
  - The accept decision is made at edge E(2+STABLE_CYCLES).
  - `digit_valid` / `pat_err` / `blank` / `digit` update at that edge and are high during the following cycle.
  - Latency is therefore STABLE_CYCLES+2 edges after E0. With the default of 4, outputs update at E6.
- A glitch shorter than STABLE_CYCLES synchronized cycles never produces an event. After the glitch, the original value restarts the filter, but matches `acc`, so no event occurs.
- `en` deasserted at any point resets `stab` the next edge. After re-enable, a full STABLE_CYCLES window is needed again.
- All pulses are exactly one cycle wide. Outputs are registered, with no combinational path from inputs.

## Test plan
- **Reset then count:** reset, then drive 3F, 06, 5B, each held 20 cycles, `STABLE_CYCLES`=4.
  - `digit_valid` fires 3 times with `digit`=0, 1, 2.
  - `blank` falls at the first event; `err_count`=0.
  - First `digit_valid` occurs 6 edges after the first sample of 3F.
- **Glitch reject:** holding 06, drive 7F for 3 synchronized cycles, then back to 06.
  - No `digit_valid`, no `pat_err`; `digit` stays 1.
- **Wrap and sequence break:** drive 71 (F), 3F (0), then 4F (3).
  - Events F, 0, 3; `seq_err`=1 after the third; `err_count`=1.
- **Illegal and blank:**
  - Drive 3F, then 01 (only segment a): `pat_err` pulses, `err_count`=1, `digit` stays 0.
  - Then drive 06: no sequence error, because state was IDLE.
  - Then drive 00 and 5B: `blank`=1 then 0, no sequence error.
- **Clear collision:** with `err_count`=5, assert `clear_err` in the same cycle a sequence break is accepted.
  - `err_count`=1, `seq_err`=1.
  - Separately, 300 illegal patterns → `err_count`=255.
- **Enable and reset mid-filter:**
  - Drop `en` for 2 cycles inside the window: the event is delayed by a full new window.
  - Assert `rst_n`=0 inside the window: all outputs return to reset values and no event fires for that pattern until it is re-filtered.
